ripple_adder: RTL and testbench

- Parameterised ripple-carry binary adder with registered outputs.
- Used in the floating-point multiplier datapath for exponent arithmetic: adds two biased exponents, then adds the two's-complement bias correction (0x781 = −127 at 11 bits).
- Built from explicitly generated 1-bit full-adder cells chained carry-to-carry.
- One clock; reset is synchronous and active-high.

---
 rtl/ripple_adder_if.sv | 31 +++
 rtl/ripple_adder.sv | 61 ++++++
 tb/tb_ripple_adder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ripple_adder_if.sv
// Operand/result bundle for ripple_adder. Carries ovf only when RIPPLE_ADDER_OVF_EN is defined.
interface ripple_adder_if #(
  parameter int unsigned WIDTH = 11
) ();
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
`ifdef RIPPLE_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin,
`ifdef RIPPLE_ADDER_OVF_EN
    input  ovf,
`endif
    input  sum, cout, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef RIPPLE_ADDER_OVF_EN
    output ovf,
`endif
    output sum, cout, out_valid
  );
endinterface

// File: rtl/ripple_adder.sv
// Ripple-carry adder built from generated full-adder cells, with a registered result.
// Define RIPPLE_ADDER_OVF_EN to add the registered signed-overflow flag ovf.
module ripple_adder #(
  parameter int unsigned WIDTH = 11
) (
  input logic           clk,
  input logic           rst,
  ripple_adder_if.slave bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic p;
    assign p          = bus.a[i] ^ bus.b[i];
    assign sum_c[i]   = p ^ carry[i];
    assign carry[i+1] = (bus.a[i] & bus.b[i]) | (p & carry[i]);
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;

  // Reset wins over in_valid, so an op presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q  <= sum_c;
        cout_q <= carry[WIDTH];
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = out_valid_q;

`ifdef RIPPLE_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_adder.sv
// Directed bench for ripple_adder at WIDTH=11; checks ovf too when RIPPLE_ADDER_OVF_EN is defined.
module tb_ripple_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  ripple_adder_if #(.WIDTH(11)) bus ();

  ripple_adder #(.WIDTH(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Present one cycle of stimulus, then land 1 time unit after the capturing edge.
  task automatic drive(input logic r, input logic v, input logic [10:0] a, input logic [10:0] b,
                       input logic c);
    rst          = r;
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 11'h7FF, 11'h7FF, 1'b1);
      checks++;
      if (bus.sum !== 11'h000) begin
        fails++; $display("FAIL reset sum cyc%0d: got %h want 000", i, bus.sum);
      end
      checks++;
      if (bus.cout !== 1'b0) begin
        fails++; $display("FAIL reset cout cyc%0d: got %b want 0", i, bus.cout);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
        fails++; $display("FAIL reset out_valid cyc%0d: got %b want 0", i, bus.out_valid);
      end
`ifdef RIPPLE_ADDER_OVF_EN
      checks++;
      if (bus.ovf !== 1'b0) begin
        fails++; $display("FAIL reset ovf cyc%0d: got %b want 0", i, bus.ovf);
      end
`endif
    end
  endtask

  task automatic test_exponent_add();
    drive(1'b0, 1'b1, 11'h082, 11'h07F, 1'b0);
    checks++;
    if (bus.sum !== 11'h101) begin
      fails++; $display("FAIL exp_add sum: got %h want 101", bus.sum);
    end
    checks++;
    if (bus.cout !== 1'b0) begin
      fails++; $display("FAIL exp_add cout: got %b want 0", bus.cout);
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      fails++; $display("FAIL exp_add out_valid: got %b want 1", bus.out_valid);
    end
  endtask

  task automatic test_bias_subtract();
    drive(1'b0, 1'b1, 11'h101, 11'h781, 1'b0);
    checks++;
    if (bus.sum !== 11'h082 || bus.cout !== 1'b1) begin
      fails++; $display("FAIL bias_sub1 sum/cout: got %h/%b want 082/1", bus.sum, bus.cout);
    end
    drive(1'b0, 1'b1, 11'h002, 11'h781, 1'b0);
    checks++;
    if (bus.sum !== 11'h783 || bus.cout !== 1'b0) begin
      fails++; $display("FAIL bias_sub2 sum/cout: got %h/%b want 783/0", bus.sum, bus.cout);
    end
  endtask

  task automatic test_carry_chain();
    drive(1'b0, 1'b1, 11'h7FF, 11'h000, 1'b1);
    checks++;
    if (bus.sum !== 11'h000 || bus.cout !== 1'b1) begin
      fails++; $display("FAIL carry_chain1 sum/cout: got %h/%b want 000/1", bus.sum, bus.cout);
    end
    drive(1'b0, 1'b1, 11'h7FF, 11'h7FF, 1'b1);
    checks++;
    if (bus.sum !== 11'h7FF || bus.cout !== 1'b1) begin
      fails++; $display("FAIL carry_chain2 sum/cout: got %h/%b want 7FF/1", bus.sum, bus.cout);
    end
    drive(1'b0, 1'b1, 11'h555, 11'h2AA, 1'b0);
    checks++;
    if (bus.sum !== 11'h7FF || bus.cout !== 1'b0) begin
      fails++; $display("FAIL carry_alt sum/cout: got %h/%b want 7FF/0", bus.sum, bus.cout);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] want;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b1, 11'(k), 11'(k), 1'b0);
      want = 11'(2 * k);
      checks++;
      if (bus.sum !== want || bus.out_valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b op%0d sum/out_valid: got %h/%b want %h/1", k, bus.sum, bus.out_valid,
                 want);
      end
    end
    drive(1'b0, 1'b0, 11'h123, 11'h456, 1'b1);
    checks++;
    if (bus.sum !== 11'h006 || bus.cout !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold sum/cout/out_valid: got %h/%b/%b want 006/0/0", bus.sum, bus.cout,
               bus.out_valid);
    end
    drive(1'b1, 1'b1, 11'h005, 11'h005, 1'b0);
    checks++;
    if (bus.sum !== 11'h000 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst sum/out_valid: got %h/%b want 000/0", bus.sum, bus.out_valid);
    end
    drive(1'b0, 1'b0, 11'h005, 11'h005, 1'b0);
    checks++;
    if (bus.sum !== 11'h000 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_rst_hold sum/out_valid: got %h/%b want 000/0", bus.sum, bus.out_valid);
    end
  endtask

`ifdef RIPPLE_ADDER_OVF_EN
  task automatic test_ovf();
    drive(1'b0, 1'b1, 11'h3FF, 11'h001, 1'b0);
    checks++;
    if (bus.sum !== 11'h400 || bus.cout !== 1'b0 || bus.ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_pos sum/cout/ovf: got %h/%b/%b want 400/0/1", bus.sum, bus.cout, bus.ovf);
    end
    drive(1'b0, 1'b1, 11'h400, 11'h7FF, 1'b0);
    checks++;
    if (bus.sum !== 11'h3FF || bus.cout !== 1'b1 || bus.ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_neg sum/cout/ovf: got %h/%b/%b want 3FF/1/1", bus.sum, bus.cout, bus.ovf);
    end
    drive(1'b0, 1'b0, 11'h000, 11'h000, 1'b0);
    checks++;
    if (bus.ovf !== 1'b1) begin
      fails++; $display("FAIL ovf_hold: got %b want 1", bus.ovf);
    end
    drive(1'b0, 1'b1, 11'h001, 11'h7FF, 1'b0);
    checks++;
    if (bus.sum !== 11'h000 || bus.cout !== 1'b1 || bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_none sum/cout/ovf: got %h/%b/%b want 000/1/0", bus.sum, bus.cout, bus.ovf);
    end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    @(negedge clk);
    test_reset();
    test_exponent_add();
    test_bias_subtract();
    test_carry_chain();
    test_back_to_back();
`ifdef RIPPLE_ADDER_OVF_EN
    test_ovf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
